// File: rtl/broadcast_scheduler_pkg.sv
// broadcast_scheduler_pkg: shared sizes, finish-flag position and encodings for the broadcast scheduler.
package broadcast_scheduler_pkg;
  localparam int NUM_PE       = 64;
  localparam int PE_IDX_WIDTH = 6;
  localparam int DATA_WIDTH   = 16;
  localparam int ADDR_WIDTH   = 16;
  localparam int FIN_BIT      = ADDR_WIDTH - 1;
  localparam int CNT_WIDTH    = PE_IDX_WIDTH + 1;
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_ISSUE, S_WAIT, S_FIN} state_e;
  typedef enum logic {MODE_SEQ = 1'b0, MODE_PAR = 1'b1} mode_e;
endpackage

// File: rtl/broadcast_scheduler_pe_next_select.sv
// pe_next_select: lowest set mask bit at or above a start index.
module pe_next_select
  import broadcast_scheduler_pkg::*;
(
  input  logic [NUM_PE-1:0]       mask_i,
  input  logic [PE_IDX_WIDTH-1:0] start_i,
  output logic [PE_IDX_WIDTH-1:0] pos_o,
  output logic                    valid_o
);
  always_comb begin
    pos_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_PE - 1; i >= 0; i--)
      if (mask_i[i] && i >= int'(start_i)) begin
        pos_o   = PE_IDX_WIDTH'(i);
        valid_o = 1'b1;
      end
  end
endmodule

// File: rtl/broadcast_scheduler.sv
// broadcast_scheduler: issues per-PE start pulses and tracks finish packets for one broadcast phase.
module broadcast_scheduler
  import broadcast_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_mode,
  input  logic [NUM_PE-1:0]     cfg_pe_mask,
  output logic [NUM_PE-1:0]     pe_start_broadcast,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [ADDR_WIDTH-1:0] rx_addr,
  output logic                  rx_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unexp,
  output logic [CNT_WIDTH-1:0]  fin_count
);
  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [NUM_PE-1:0]       mask_q, mask_d, fin_q, fin_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PE_IDX_WIDTH-1:0] ptr_q, ptr_d, nxt_pos, idx;
  logic                    err_q, err_d, nxt_valid, is_fin, malformed, bad;
  logic [NUM_PE-1:0]       idx_bit, fin_nxt;
  logic                    addr_unused;
  pe_next_select u_next (
    .mask_i (mask_q),
    .start_i(ptr_q),
    .pos_o  (nxt_pos),
    .valid_o(nxt_valid)
  );
  assign addr_unused = ^rx_addr[FIN_BIT-1:0];
  assign is_fin      = rx_valid && rx_addr[FIN_BIT];
  assign malformed   = rx_data[DATA_WIDTH-1:PE_IDX_WIDTH] != '0;
  assign idx         = rx_data[PE_IDX_WIDTH-1:0];
  assign idx_bit     = NUM_PE'(1) << idx;
  assign fin_nxt     = fin_q | idx_bit;
  assign bad         = !mask_q[idx] || fin_q[idx] || (mode_q == MODE_SEQ && idx != ptr_q);
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    fin_d   = fin_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q | (is_fin && malformed);
    case (state_q)
      S_IDLE: if (cfg_start) begin
        mask_d  = cfg_pe_mask;
        mode_d  = mode_e'(cfg_mode);
        fin_d   = '0;
        cnt_d   = '0;
        ptr_d   = '0;
        err_d   = 1'b0;
        state_d = S_SEL;
      end
      S_SEL: if (mode_q == MODE_SEQ) begin
        ptr_d   = nxt_valid ? nxt_pos : ptr_q;
        state_d = nxt_valid ? S_ISSUE : S_FIN;
      end else state_d = |mask_q ? S_ISSUE : S_FIN;
      S_ISSUE: state_d = S_WAIT;
      // Finishing the whole mask goes straight to FIN so done follows the last finish by one cycle.
      S_WAIT: if (is_fin && !malformed) begin
        if (bad) err_d = 1'b1;
        else begin
          fin_d   = fin_nxt;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = fin_nxt == mask_q ? S_FIN : (mode_q == MODE_SEQ ? S_SEL : S_WAIT);
          ptr_d   = (mode_q == MODE_SEQ && fin_nxt != mask_q) ? ptr_q + PE_IDX_WIDTH'(1) : ptr_q;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SEQ;
      mask_q  <= '0;
      fin_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  assign pe_start_broadcast = state_q != S_ISSUE ? '0 : (mode_q == MODE_PAR ? mask_q : NUM_PE'(1) << ptr_q);
  assign rx_rdy    = 1'b1;
  assign busy      = state_q == S_SEL || state_q == S_ISSUE || state_q == S_WAIT;
  assign done      = state_q == S_FIN;
  assign err_unexp = err_q;
  assign fin_count = cnt_q;
endmodule

// File: tb/tb_broadcast_scheduler.sv
// tb_broadcast_scheduler: randomized phases against a set-based reference model with a scoreboard monitor.
module tb_broadcast_scheduler;
  import broadcast_scheduler_pkg::*;
  logic                  clk = 1'b0, rst = 1'b1, cfg_start = 1'b0, cfg_mode = 1'b0, rx_valid = 1'b0;
  logic [NUM_PE-1:0]     cfg_pe_mask = '0;
  logic [DATA_WIDTH-1:0] rx_data = '0;
  logic [ADDR_WIDTH-1:0] rx_addr = '0;
  logic [NUM_PE-1:0]     pe_start_broadcast;
  logic                  rx_rdy, busy, done, err_unexp;
  logic [CNT_WIDTH-1:0]  fin_count;
  broadcast_scheduler dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_pe_mask(cfg_pe_mask),
    .pe_start_broadcast(pe_start_broadcast), .rx_valid(rx_valid), .rx_data(rx_data), .rx_addr(rx_addr),
    .rx_rdy(rx_rdy), .busy(busy), .done(done), .err_unexp(err_unexp), .fin_count(fin_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passes = 0;
  typedef struct {
    bit          is_done;
    logic [63:0] val;
    int          at;
    int          cnt;
    bit          err;
  } exp_t;
  exp_t q[$];
  logic [63:0] m_mask, m_fin;
  bit          m_par, m_err;
  int          m_cnt, m_ptr, m_next;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk)
    if (!rst && (pe_start_broadcast != '0 || done)) begin
      exp_t e;
      if (q.size() == 0) chk("unexpected_output", pe_start_broadcast | 64'(done), 64'd0);
      else begin
        e = q.pop_front();
        chk("done_vs_pulse", 64'(done), 64'(e.is_done));
        chk("pulse_value", pe_start_broadcast, e.is_done ? 64'd0 : e.val);
        chk("event_cycle", 64'(cyc), 64'(e.at));
        chk("fin_count", 64'(fin_count), 64'(e.cnt));
        chk("err_unexp", 64'(err_unexp), 64'(e.err));
        chk("busy", 64'(busy), 64'(!e.is_done));
        chk("rx_rdy", 64'(rx_rdy), 64'd1);
      end
    end
  function automatic int lowest_from(input logic [63:0] m, input int from);
    for (int i = from; i < 64; i++) if (m[i]) return i;
    return -1;
  endfunction
  function automatic int pick(input logic [63:0] m);
    int t;
    t = lowest_from(m, int'($urandom_range(0, 63)));
    return t < 0 ? lowest_from(m, 0) : t;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask
  task automatic push(input bit d, input logic [63:0] v, input int at, input int cnt, input bit err);
    exp_t e;
    e.is_done = d; e.val = v; e.at = at; e.cnt = cnt; e.err = err;
    q.push_back(e);
  endtask
  task automatic pkt(input logic [15:0] addr, input logic [15:0] data);
    rx_valid = 1'b1; rx_addr = addr; rx_data = data;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic start_phase(input logic [63:0] mask, input bit par);
    m_mask = mask; m_par = par; m_fin = '0; m_err = 1'b0; m_cnt = 0;
    m_ptr = lowest_from(mask, 0);
    cfg_start = 1'b1; cfg_pe_mask = mask; cfg_mode = par;
    if (mask == '0) push(1'b1, '0, cyc + 2, 0, 1'b0);
    else push(1'b0, par ? mask : 64'(1) << m_ptr, cyc + 2, 0, 1'b0);
    m_next = cyc + 3;
    tick();
    cfg_start = 1'b0;
  endtask
  // Well-formed finish: accepted only for an enabled, unfinished PE that is the current one in sequential mode.
  task automatic fin_pkt(input int idx);
    int  c;
    bit  ok;
    c  = cyc;
    ok = m_mask[idx] && !m_fin[idx] && (m_par || idx == m_ptr);
    pkt({1'b1, 15'($urandom)}, 16'(idx));
    if (!ok) m_err = 1'b1;
    else begin
      m_fin[idx] = 1'b1;
      m_cnt++;
      if (m_fin == m_mask) begin
        push(1'b1, '0, c + 1, m_cnt, m_err);
        m_next = c + 2;
      end else if (!m_par) begin
        m_ptr = lowest_from(m_mask, idx + 1);
        push(1'b0, 64'(1) << m_ptr, c + 2, m_cnt, m_err);
        m_next = c + 3;
      end
    end
  endtask
  task automatic bad_pkt(input logic [15:0] d);
    m_err = 1'b1;
    pkt({1'b1, 15'($urandom)}, d);
  endtask
  task automatic drain(input bit noise);
    int r;
    while (m_fin != m_mask) begin
      wait_until(m_next);
      r = noise ? int'($urandom_range(0, 5)) : 5;
      if (r == 0) pkt({1'b0, 15'($urandom)}, 16'($urandom));
      else if (r == 1) bad_pkt(16'($urandom) | (16'h0040 << $urandom_range(0, 9)));
      else if (r == 2) fin_pkt(int'($urandom_range(0, 63)));
      else if (r == 3) begin
        cfg_start = 1'b1; cfg_pe_mask = {$urandom, $urandom}; cfg_mode = 1'($urandom);
        tick();
        cfg_start = 1'b0;
      end else fin_pkt(m_par ? pick(m_mask & ~m_fin) : m_ptr);
    end
    wait_until(m_next);
  endtask
  task automatic run_phase(input logic [63:0] mask, input bit par, input bit noise);
    start_phase(mask, par);
    drain(noise);
  endtask
  initial begin
    logic [63:0] m;
    tick();
    tick();
    chk("reset_pulses", pe_start_broadcast, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err_unexp), 64'd0);
    chk("reset_fin_count", 64'(fin_count), 64'd0);
    chk("reset_rx_rdy", 64'(rx_rdy), 64'd1);
    rst = 1'b0;
    tick();
    run_phase(64'h5, 1'b0, 1'b0);
    run_phase(64'hF, 1'b1, 1'b0);
    run_phase(64'h0, 1'b0, 1'b0);
    run_phase(64'h0, 1'b1, 1'b0);
    run_phase(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    start_phase(64'h5, 1'b0);
    wait_until(m_next);
    fin_pkt(5);
    pkt(16'h0123, 16'h0000);
    drain(1'b0);
    start_phase(64'hF, 1'b1);
    wait_until(m_next);
    fin_pkt(3);
    fin_pkt(1);
    fin_pkt(1);
    bad_pkt(16'h0440);
    fin_pkt(0);
    fin_pkt(0);
    fin_pkt(2);
    wait_until(m_next);
    run_phase('1, 1'b1, 1'b1);
    run_phase('1, 1'b0, 1'b0);
    start_phase(64'hF0, 1'b1);
    wait_until(m_next);
    bad_pkt(16'h0440);
    fin_pkt(5);
    chk("pre_reset_fin_count", 64'(fin_count), 64'd1);
    chk("pre_reset_err", 64'(err_unexp), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_pulses", pe_start_broadcast, 64'd0);
    chk("async_rst_fin_count", 64'(fin_count), 64'd0);
    chk("async_rst_err", 64'(err_unexp), 64'd0);
    chk("async_rst_rx_rdy", 64'(rx_rdy), 64'd1);
    chk("queue_empty_at_reset", 64'(q.size()), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_phase(64'h30, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      m = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: m = m & {$urandom, $urandom} & {$urandom, $urandom};
        1: m = 64'(1) << $urandom_range(0, 63);
        2: m = m | {$urandom, $urandom};
        default: ;
      endcase
      run_phase(m, 1'($urandom), 1'b1);
    end
    wait_until(cyc + 5);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
